// File: rtl/press_event_decoder.sv
// press_event_decoder
//
// Turns the debounced button level into one of three gesture events:
// single press, double press or long press. Each event is a one-cycle
// registered pulse. All timing is counted in CLK cycles.
//
// Optional feature macro: PRESS_DECODER_REPEAT_EN
//   When defined, holding the button after a long press produces an
//   auto-repeat pulse every Repeat_Interval cycles. When undefined, the
//   repeat logic is absent and Repeat_Pulse is tied low.
//
// Parameters:
//   Long_Press_Length   - cycles held after the press to qualify as long
//   Double_Click_Window - cycles after first release in which a second
//                         press counts as a double press
//   Repeat_Interval     - cycles between auto-repeat pulses
//
// Ports:
//   CLK           in   system clock, posedge
//   Reset         in   asynchronous active-high reset
//   Button_In     in   debounced button level, synchronous to CLK
//   Single_Press  out  one-cycle pulse, single press
//   Double_Press  out  one-cycle pulse, double press
//   Long_Press    out  one-cycle pulse, long press
//   Repeat_Pulse  out  one-cycle auto-repeat pulse
//   Current_State out  debug: FSM state encoding
//   Timer         out  debug: in-state cycle counter (saturating)

module press_event_decoder #(
    parameter logic [25:0] Long_Press_Length   = 26'd50000000,
    parameter logic [25:0] Double_Click_Window = 26'd15000000,
    parameter logic [25:0] Repeat_Interval     = 26'd10000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Button_In,
    output logic        Single_Press,
    output logic        Double_Press,
    output logic        Long_Press,
    output logic        Repeat_Pulse,
    output logic [2:0]  Current_State,
    output logic [25:0] Timer
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED1  = 3'd1,
        WAIT2     = 3'd2,
        PRESSED2  = 3'd3,
        HELD_LONG = 3'd4
    } state_t;

    localparam logic [25:0] TIMER_MAX = 26'h3FFFFFF;

    state_t state;
    logic   button_prev;
    logic   rise;

    // button_prev resets high so a button already held at reset release
    // is not seen as a new press.
    assign rise          = Button_In & ~button_prev;
    assign Current_State = state;

    // Gesture FSM. Timer counts cycles spent in the current state; each
    // transition branch clears it, overriding the default increment.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            Timer        <= 26'd0;
            button_prev  <= 1'b1;
            Single_Press <= 1'b0;
            Double_Press <= 1'b0;
            Long_Press   <= 1'b0;
        end else begin
            button_prev  <= Button_In;
            Single_Press <= 1'b0;
            Double_Press <= 1'b0;
            Long_Press   <= 1'b0;
            if (Timer != TIMER_MAX) begin
                Timer <= Timer + 26'd1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESSED1;
                        Timer <= 26'd0;
                    end
                end
                PRESSED1: begin
                    if (!Button_In) begin
                        state <= WAIT2;
                        Timer <= 26'd0;
                    end else if (Timer == Long_Press_Length - 26'd1) begin
                        Long_Press <= 1'b1;
                        state      <= HELD_LONG;
                        Timer      <= 26'd0;
                    end
                end
                WAIT2: begin
                    // A second press on the expiry cycle still counts as a
                    // double press, so rise is checked first.
                    if (rise) begin
                        Double_Press <= 1'b1;
                        state        <= PRESSED2;
                        Timer        <= 26'd0;
                    end else if (Timer == Double_Click_Window - 26'd1) begin
                        Single_Press <= 1'b1;
                        state        <= IDLE;
                        Timer        <= 26'd0;
                    end
                end
                PRESSED2: begin
                    if (!Button_In) begin
                        state <= IDLE;
                        Timer <= 26'd0;
                    end
                end
                HELD_LONG: begin
                    if (!Button_In) begin
                        state <= IDLE;
                        Timer <= 26'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Timer <= 26'd0;
                end
            endcase
        end
    end

`ifdef PRESS_DECODER_REPEAT_EN
    logic [25:0] repeat_count;

    // The repeat counter idles at zero outside HELD_LONG, which clears it
    // on entry and on exit without a separate entry detect.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            repeat_count <= 26'd0;
            Repeat_Pulse <= 1'b0;
        end else begin
            Repeat_Pulse <= 1'b0;
            if (state == HELD_LONG && Button_In) begin
                if (repeat_count == Repeat_Interval - 26'd1) begin
                    Repeat_Pulse <= 1'b1;
                    repeat_count <= 26'd0;
                end else begin
                    repeat_count <= repeat_count + 26'd1;
                end
            end else begin
                repeat_count <= 26'd0;
            end
        end
    end
`else
    logic unused_repeat_interval;

    assign unused_repeat_interval = ^Repeat_Interval;
    assign Repeat_Pulse           = 1'b0;
`endif

endmodule

// File: doc/press_event_decoder.md
Name: press_event_decoder

Overview:
- Consumes the debounced button level from the upstream debounce stage and classifies each gesture into one of three events: single press, double press or long press.
- Each event is a one-cycle registered pulse for the menu/control logic downstream.
- Single clock domain; all timing is in CLK cycles (50 MHz nominal).

Parameters:
Long_Press_Length, 26'd50000000, cycles the button must stay high after a press to qualify as a long press (1 s).
Double_Click_Window, 26'd15000000, cycles after the first release during which a second press counts as a double press (300 ms).
Repeat_Interval, 26'd10000000, cycles between auto-repeat pulses while a long press is held (PRESS_DECODER_REPEAT_EN only).

Ports:
CLK  input  1  system clock, all logic on posedge
Reset  input  1  asynchronous, active-high reset
Button_In  input  1  debounced button level from the debounce stage, already synchronous to CLK
Single_Press  output  1  one-cycle pulse, single press classified
Double_Press  output  1  one-cycle pulse, double press classified
Long_Press  output  1  one-cycle pulse, long press classified
Repeat_Pulse  output  1  one-cycle auto-repeat pulse (tied 0 when feature is compiled out)
Current_State  output  3  debug: FSM state encoding
Timer  output  26  debug: in-state cycle counter

Behaviour:
- Reset (async, Reset=1):
  - state=IDLE, Timer=0.
  - All pulse outputs=0.
  - Button_Prev=1, so a button held through reset release produces no event.
- Edge detect: Rise = Button_In & ~Button_Prev. Button_Prev <= Button_In every cycle.
- Timer:
  - Cleared to 0 on every state change.
  - Otherwise increments by 1 per cycle.
  - Saturates at 26'h3FFFFFF; it never wraps.
- States: IDLE=0, PRESSED1=1, WAIT2=2, PRESSED2=3, HELD_LONG=4. Encodings 5-7 return to IDLE on the next cycle.
- IDLE: Rise -> PRESSED1.
- PRESSED1:
  - Button_In=0 -> WAIT2.
  - Else Timer==Long_Press_Length-1 -> Long_Press=1 for one cycle, go to HELD_LONG.
- WAIT2:
  - Rise -> Double_Press=1 for one cycle, go to PRESSED2.
  - Else Timer==Double_Click_Window-1 -> Single_Press=1 for one cycle, go to IDLE.
  - Rise in the same cycle as expiry: Double_Press wins, Single_Press stays 0.
- PRESSED2: Button_In=0 -> IDLE. No long-press detection after a double press.
- HELD_LONG: Button_In=0 -> IDLE.
- All outputs are registered. A pulse is high in the cycle immediately after the clock edge that takes the transition.
- Latencies:
  - Single_Press: Double_Click_Window cycles after the first falling edge is sampled.
  - Long_Press: Long_Press_Length cycles after the rising edge is sampled.
- At most one of Single_Press, Double_Press and Long_Press is high in any cycle.
- Reset asserted mid-gesture: the gesture is discarded and no event is emitted.

Optional Feature:
- Macro: PRESS_DECODER_REPEAT_EN.
- Defined:
  - In HELD_LONG, a separate repeat counter is cleared on entry.
  - Repeat_Pulse=1 for one cycle every Repeat_Interval cycles while Button_In=1. The first pulse comes Repeat_Interval cycles after Long_Press.
  - The counter clears on each pulse and on exit from HELD_LONG.
- Undefined: the repeat counter and its logic are absent. Repeat_Pulse is tied to 1'b0.

Test Plan:
Use sim parameters Long_Press_Length=20, Double_Click_Window=10, Repeat_Interval=5 for all scenarios.
1. Single press: high for 5 cycles, then low -> Single_Press is one pulse 10 cycles after the fall sample. No other pulses.
2. Double press: high 5, low 4, high 3, low -> Double_Press is one pulse on the cycle after the second rise. No Single_Press ever.
3. Long press: high for 30 cycles -> Long_Press pulses 20 cycles after the rise. Release returns the FSM to IDLE with no further pulses.
4. Collision: the second rise lands exactly in the WAIT2 cycle where Timer==9 -> only Double_Press pulses.
5. Reset cases:
   - Button held high across reset release, then low -> no events.
   - Reset asserted during WAIT2 -> no Single_Press; state=0 and Timer=0 immediately, asynchronously.
6. Repeat (macro defined): hold for 40 cycles -> Long_Press at 20, then Repeat_Pulse at 25, 30, 35, 40. With the macro undefined, Repeat_Pulse stays 0 throughout.
